// File: rtl/oc8051_xrom_fetch.sv
// oc8051_xrom_fetch: answers the core's istb/iack instruction fetch by reading three
// consecutive bytes from byte-wide program memory. Optional macro OC8051_XROM_HIT_EN adds a repeat-fetch hit.
module oc8051_xrom_fetch #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        istb_i,
  input  logic [15:0] iadr_i,
  output logic        iack_o,
  output logic [7:0]  op1_o,
  output logic [7:0]  op2_o,
  output logic [7:0]  op3_o,
  output logic        mem_rd_o,
  output logic [15:0] mem_adr_o,
  input  logic [7:0]  mem_dat_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_ACK} state_e;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        iack_q, iack_d;
  logic        mem_rd_q, mem_rd_d;
  logic [15:0] mem_adr_q, mem_adr_d;
  logic [2:0]  op_ld;
  logic        hit;
  logic        hit_set;
  logic        hit_clr;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    iack_d    = 1'b0;
    mem_rd_d  = mem_rd_q;
    mem_adr_d = mem_adr_q;
    op_ld     = 3'b000;
    hit_set   = 1'b0;
    hit_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_rd_d = 1'b0;
        if (istb_i) begin
          if (hit) begin
            state_d = ST_ACK;
            iack_d  = 1'b1;
          end else begin
            state_d   = ST_READ;
            idx_d     = 2'd0;
            wcnt_d    = 4'd0;
            mem_rd_d  = 1'b1;
            mem_adr_d = iadr_i;
            hit_clr   = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (!istb_i) begin
          state_d  = ST_IDLE;
          mem_rd_d = 1'b0;
          hit_clr  = 1'b1;
        end else if (wcnt_q != WAIT_LAST) begin
          wcnt_d = wcnt_q + 4'd1;
        end else begin
          op_ld[idx_q] = 1'b1;
          wcnt_d       = 4'd0;
          if (idx_q == 2'd2) begin
            state_d  = ST_ACK;
            mem_rd_d = 1'b0;
            iack_d   = 1'b1;
            hit_set  = 1'b1;
          end else begin
            idx_d     = idx_q + 2'd1;
            mem_adr_d = mem_adr_q + 16'd1;
          end
        end
      end
      ST_ACK: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 2'd0;
      wcnt_q    <= 4'd0;
      iack_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_adr_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      iack_q    <= iack_d;
      mem_rd_q  <= mem_rd_d;
      mem_adr_q <= mem_adr_d;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_op
    logic [7:0] byte_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        byte_q <= 8'h00;
      end else if (op_ld[gi]) begin
        byte_q <= mem_dat_i;
      end
    end
  end

`ifdef OC8051_XROM_HIT_EN
  logic        hit_vld_q;
  logic [15:0] last_adr_q;

  // On the final byte the address register sits at A+2, so A is recovered by subtraction.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_vld_q  <= 1'b0;
      last_adr_q <= 16'h0000;
    end else if (hit_set) begin
      hit_vld_q  <= 1'b1;
      last_adr_q <= mem_adr_q - 16'd2;
    end else if (hit_clr) begin
      hit_vld_q  <= 1'b0;
    end
  end

  assign hit = hit_vld_q && (iadr_i == last_adr_q);
`else
  logic unused_hit;
  assign unused_hit = hit_set ^ hit_clr;
  assign hit        = 1'b0;
`endif

  assign iack_o    = iack_q;
  assign mem_rd_o  = mem_rd_q;
  assign mem_adr_o = mem_adr_q;
  assign op1_o     = g_op[0].byte_q;
  assign op2_o     = g_op[1].byte_q;
  assign op3_o     = g_op[2].byte_q;

endmodule

// File: tb/tb_oc8051_xrom_fetch.sv
// Scoreboard bench for oc8051_xrom_fetch: unit 0 uses WAIT_STATES=1, unit 1 uses WAIT_STATES=0.
module tb_oc8051_xrom_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       istb;
  logic [1:0][15:0] iadr;
  logic [1:0]       iack;
  logic [1:0][7:0]  op1, op2, op3;
  logic [1:0]       mem_rd;
  logic [1:0][15:0] mem_adr;
  logic [1:0][7:0]  mem_dat;
  logic [7:0]       mem [0:65535];

  assign mem_dat[0] = mem[mem_adr[0]];
  assign mem_dat[1] = mem[mem_adr[1]];

  oc8051_xrom_fetch #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst[0]), .istb_i(istb[0]), .iadr_i(iadr[0]), .iack_o(iack[0]),
    .op1_o(op1[0]), .op2_o(op2[0]), .op3_o(op3[0]),
    .mem_rd_o(mem_rd[0]), .mem_adr_o(mem_adr[0]), .mem_dat_i(mem_dat[0])
  );

  oc8051_xrom_fetch #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst[1]), .istb_i(istb[1]), .iadr_i(iadr[1]), .iack_o(iack[1]),
    .op1_o(op1[1]), .op2_o(op2[1]), .op3_o(op3[1]),
    .mem_rd_o(mem_rd[1]), .mem_adr_o(mem_adr[1]), .mem_dat_i(mem_dat[1])
  );

  typedef struct {
    int         unit;
    int         start;
    int         lat;
    logic [7:0] o1;
    logic [7:0] o2;
    logic [7:0] o3;
  } exp_t;

  typedef struct {
    int          unit;
    logic [15:0] adr;
  } adr_t;

  exp_t exp_q[$];
  adr_t adr_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef OC8051_XROM_HIT_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws(int u);
    return (u == 0) ? 1 : 0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic int find_adr(int u);
    for (int i = 0; i < adr_q.size(); i++) if (adr_q[i].unit == u) return i;
    return -1;
  endfunction

  function automatic int find_exp(int u);
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].unit == u) return i;
    return -1;
  endfunction

  task automatic push_exp(int u, int start, int lat, logic [7:0] e1, logic [7:0] e2, logic [7:0] e3);
    exp_t e;
    e.unit = u; e.start = start; e.lat = lat; e.o1 = e1; e.o2 = e2; e.o3 = e3;
    exp_q.push_back(e);
  endtask

  task automatic push_adrs(int u, logic [15:0] a, int nbytes);
    adr_t r;
    for (int k = 0; k < nbytes; k++) begin
      for (int w = 0; w <= ws(u); w++) begin
        r.unit = u;
        r.adr  = a + 16'(k);
        adr_q.push_back(r);
      end
    end
  endtask

  task automatic wait_ack(int u);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!iack[u] && n < 60);
    if (!iack[u]) begin
      checks++;
      errors++;
      $display("FAIL u%0d ack_timeout: got no iack_o, required iack_o within 60 cycles", u);
    end
  endtask

  // Strobe issued on a falling edge; the following rising edge is edge 0 of the fetch.
  task automatic fetch(int u, logic [15:0] a, int lat, logic [7:0] e1, logic [7:0] e2,
                       logic [7:0] e3, bit reads);
    @(negedge clk);
    istb[u] = 1'b1;
    iadr[u] = a;
    push_exp(u, cyc, lat, e1, e2, e3);
    if (reads) push_adrs(u, a, 3);
    wait_ack(u);
    istb[u] = 1'b0;
    iadr[u] = 16'h0000;
  endtask

  always @(negedge clk) begin
    int i;
    for (int u = 0; u < 2; u++) begin
      if (mem_rd[u]) begin
        i = find_adr(u);
        if (i < 0) begin
          checks++;
          errors++;
          $display("FAIL u%0d unexpected_read: mem_adr_o=%h, required mem_rd_o=0", u, mem_adr[u]);
        end else begin
          chk($sformatf("u%0d mem_adr_o", u), 32'(mem_adr[u]), 32'(adr_q[i].adr));
          adr_q.delete(i);
        end
      end
      if (iack[u]) begin
        i = find_exp(u);
        if (i < 0) begin
          checks++;
          errors++;
          $display("FAIL u%0d unexpected_ack: iack_o=1, required 0", u);
        end else begin
          chk($sformatf("u%0d ack_latency", u), 32'(cyc - exp_q[i].start), 32'(exp_q[i].lat));
          chk($sformatf("u%0d op1_o", u), 32'(op1[u]), 32'(exp_q[i].o1));
          chk($sformatf("u%0d op2_o", u), 32'(op2[u]), 32'(exp_q[i].o2));
          chk($sformatf("u%0d op3_o", u), 32'(op3[u]), 32'(exp_q[i].o3));
          $display("ack u%0d ops=%h %h %h latency=%0d", u, op1[u], op2[u], op3[u], cyc - exp_q[i].start);
          exp_q.delete(i);
        end
        if (mem_rd[u]) begin
          checks++;
          errors++;
          $display("FAIL u%0d rd_in_ack: mem_rd_o=1, required 0", u);
        end
      end
    end
  end

  task automatic chk_zero(int u, string tag);
    chk({tag, " iack_o"},    32'(iack[u]),    32'h0);
    chk({tag, " mem_rd_o"},  32'(mem_rd[u]),  32'h0);
    chk({tag, " mem_adr_o"}, 32'(mem_adr[u]), 32'h0);
    chk({tag, " op1_o"},     32'(op1[u]),     32'h0);
    chk({tag, " op2_o"},     32'(op2[u]),     32'h0);
    chk({tag, " op3_o"},     32'(op3[u]),     32'h0);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
    mem[16'h0100] = 8'h12; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h56;
    mem[16'h0200] = 8'h21; mem[16'h0201] = 8'h43; mem[16'h0202] = 8'h65;
    mem[16'h0010] = 8'hA0; mem[16'h0011] = 8'hA1; mem[16'h0012] = 8'hA2;
    mem[16'h0013] = 8'hB3; mem[16'h0014] = 8'hB4; mem[16'h0015] = 8'hB5;
    mem[16'hFFFF] = 8'hAA; mem[16'h0000] = 8'hBB; mem[16'h0001] = 8'hCC;

    rst  = 2'b11;
    istb = 2'b00;
    iadr = '0;
    repeat (2) @(negedge clk);
    chk_zero(0, "reset u0");
    chk_zero(1, "reset u1");
    rst = 2'b00;

    // basic fetch, then an immediate re-strobe of the same address
    fetch(0, 16'h0100, 7, 8'h12, 8'h34, 8'h56, 1'b1);
    if (HIT_EN) fetch(0, 16'h0100, 1, 8'h12, 8'h34, 8'h56, 1'b0);
    else        fetch(0, 16'h0100, 7, 8'h12, 8'h34, 8'h56, 1'b1);

    // abort: strobe dropped during cycle 3 (byte 1)
    @(negedge clk);
    istb[0] = 1'b1;
    iadr[0] = 16'h0300;
    push_adrs(0, 16'h0300, 1);
    push_adrs(0, 16'h0301, 0);
    adr_q.push_back('{0, 16'h0301});
    repeat (3) @(negedge clk);
    istb[0] = 1'b0;
    @(negedge clk);
    chk("abort mem_rd_o", 32'(mem_rd[0]), 32'h0);
    chk("abort iack_o", 32'(iack[0]), 32'h0);
    repeat (2) @(negedge clk);
    fetch(0, 16'h0200, 7, 8'h21, 8'h43, 8'h65, 1'b1);

    // back-to-back: strobe held high across two fetches
    @(negedge clk);
    istb[0] = 1'b1;
    iadr[0] = 16'h0010;
    push_exp(0, cyc, 7, 8'hA0, 8'hA1, 8'hA2);
    push_adrs(0, 16'h0010, 3);
    wait_ack(0);
    iadr[0] = 16'h0013;
    push_exp(0, cyc + 1, 7, 8'hB3, 8'hB4, 8'hB5);
    push_adrs(0, 16'h0013, 3);
    @(negedge clk);
    chk("b2b gap iack_o", 32'(iack[0]), 32'h0);
    chk("b2b gap mem_rd_o", 32'(mem_rd[0]), 32'h0);
    wait_ack(0);
    istb[0] = 1'b0;
    iadr[0] = 16'h0000;

    // reset while byte 1 is being read
    @(negedge clk);
    istb[0] = 1'b1;
    iadr[0] = 16'h0100;
    adr_q.push_back('{0, 16'h0100});
    adr_q.push_back('{0, 16'h0100});
    adr_q.push_back('{0, 16'h0101});
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk_zero(0, "midrst");
    rst[0]  = 1'b0;
    istb[0] = 1'b0;
    @(negedge clk);
    c = cyc;
    chk("midrst no ack", 32'(iack[0]), 32'h0);
    fetch(0, 16'h0100, 7, 8'h12, 8'h34, 8'h56, 1'b1);

    // zero wait states, address wrap at FFFF
    fetch(1, 16'hFFFF, 4, 8'hAA, 8'hBB, 8'hCC, 1'b1);
    fetch(1, 16'h0100, 4, 8'h12, 8'h34, 8'h56, 1'b1);

    repeat (4) @(negedge clk);
    chk("adr_q drained", 32'(adr_q.size()), 32'h0);
    chk("exp_q drained", 32'(exp_q.size()), 32'h0);
    if (c < 0) $display("cycle counter wrapped");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
